// File: rtl/icm42688_ctrl.sv
// Autonomous SPI (mode 0) controller for the ICM-42688-P: power-up wait, WHO_AM_I check,
// configuration, then periodic 14-byte burst reads. Define ICM42688_DRDY_POLL_EN to gate bursts on DATA_RDY.
module icm42688_ctrl #(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int SPI_CLK_HZ = 1_000_000,
  parameter int CLK_DIV    = SYS_CLK_HZ / (2 * SPI_CLK_HZ),
  parameter int SAMPLE_HZ  = 1000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic signed [15:0] accel_x_o,
  output logic signed [15:0] accel_y_o,
  output logic signed [15:0] accel_z_o,
  output logic signed [15:0] gyro_x_o,
  output logic signed [15:0] gyro_y_o,
  output logic signed [15:0] gyro_z_o,
  output logic signed [15:0] temp_o,
  output logic               data_valid_o,
  output logic               init_done_o,
  output logic               error_o,
  output logic               spi_sck_o,
  output logic               spi_mosi_o,
  input  logic               spi_miso_i,
  output logic               spi_cs_n_o
);

  localparam int MS_CYC    = (SYS_CLK_HZ / 1000 > 0) ? SYS_CLK_HZ / 1000 : 1;
  localparam int RETRY_CYC = 10 * MS_CYC;
  localparam int SMP_CYC   = (SYS_CLK_HZ / SAMPLE_HZ > 0) ? SYS_CLK_HZ / SAMPLE_HZ : 1;
  localparam int DW        = $clog2(2 * CLK_DIV + 1);

  // ---------------- SPI byte engine ----------------
  typedef enum logic [1:0] {E_IDLE, E_LOW, E_HIGH, E_GUARD} estate_t;

  estate_t       est_q;
  logic [DW-1:0] div_q;
  logic [2:0]    bit_q;
  logic [3:0]    byte_q;
  logic [7:0]    tx_q, rx_q;
  logic [7:0]    rx_buf_q [14];
  logic          sck_q, mosi_q, cs_n_q, xfer_end_q;

  // request registers driven by the control FSM
  logic          start_q;
  logic [7:0]    cmd_q, wdat_q;
  logic [3:0]    nbytes_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      est_q      <= E_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      xfer_end_q <= 1'b0;
      for (int i = 0; i < 14; i++) rx_buf_q[i] <= '0;
    end else begin
      xfer_end_q <= 1'b0;
      case (est_q)
        E_IDLE: begin
          if (start_q) begin
            cs_n_q <= 1'b0;
            tx_q   <= cmd_q;
            mosi_q <= cmd_q[7];
            div_q  <= '0;
            bit_q  <= '0;
            byte_q <= '0;
            est_q  <= E_LOW;
          end
        end
        E_LOW: begin
          if (div_q == DW'(CLK_DIV - 1)) begin
            div_q <= '0;
            sck_q <= 1'b1;
            rx_q  <= {rx_q[6:0], spi_miso_i};
            est_q <= E_HIGH;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        E_HIGH: begin
          if (div_q == DW'(CLK_DIV - 1)) begin
            div_q <= '0;
            sck_q <= 1'b0;
            if (bit_q == 3'd7) begin
              if (byte_q != 4'd0) rx_buf_q[byte_q - 4'd1] <= rx_q;
              if (byte_q == nbytes_q - 4'd1) begin
                cs_n_q     <= 1'b1;
                mosi_q     <= 1'b0;
                xfer_end_q <= 1'b1;
                est_q      <= E_GUARD;
              end else begin
                // only a write carries a payload byte; read bytes clock out zeros
                tx_q   <= (byte_q == 4'd0) ? wdat_q : 8'h00;
                mosi_q <= (byte_q == 4'd0) ? wdat_q[7] : 1'b0;
                byte_q <= byte_q + 4'd1;
                bit_q  <= '0;
                est_q  <= E_LOW;
              end
            end else begin
              tx_q   <= {tx_q[6:0], 1'b0};
              mosi_q <= tx_q[6];
              bit_q  <= bit_q + 3'd1;
              est_q  <= E_LOW;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: begin
          if (div_q == DW'(2 * CLK_DIV - 1)) begin
            div_q <= '0;
            est_q <= E_IDLE;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- control FSM ----------------
  typedef enum logic [3:0] {
    S_PWR_WAIT, S_WHO_REQ, S_WHO_WAIT, S_RETRY,
    S_CFG_REQ, S_CFG_WAIT, S_CFG_DLY,
    S_RUN, S_BURST_REQ, S_BURST_WAIT,
    S_POLL_REQ, S_POLL_WAIT, S_POLL_DLY
  } state_t;

  state_t      st_q;
  logic [31:0] tmr_q, smp_q;
  logic        tick_q;
  logic [1:0]  cfg_idx_q;
  logic [15:0] ax_q, ay_q, az_q, gx_q, gy_q, gz_q, tp_q;
  logic        dv_q, done_q, err_q;
  logic        eng_idle;

  assign eng_idle = (est_q == E_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q      <= S_PWR_WAIT;
      tmr_q     <= 32'(MS_CYC - 1);
      smp_q     <= '0;
      tick_q    <= 1'b0;
      cfg_idx_q <= '0;
      start_q   <= 1'b0;
      cmd_q     <= '0;
      wdat_q    <= '0;
      nbytes_q  <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
      az_q      <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
      gz_q      <= '0;
      tp_q      <= '0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      dv_q    <= 1'b0;
      // sample ticks latch as pending so a slow burst leads straight into the next one
      if (smp_q == 32'(SMP_CYC - 1)) begin
        smp_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        smp_q <= smp_q + 32'd1;
      end
      case (st_q)
        S_PWR_WAIT: begin
          if (tmr_q == 32'd0) st_q <= S_WHO_REQ;
          else tmr_q <= tmr_q - 32'd1;
        end
        S_WHO_REQ: begin
          if (eng_idle) begin
            start_q  <= 1'b1;
            cmd_q    <= 8'hF5;
            wdat_q   <= 8'h00;
            nbytes_q <= 4'd2;
            st_q     <= S_WHO_WAIT;
          end
        end
        S_WHO_WAIT: begin
          if (xfer_end_q) begin
            if (rx_buf_q[0] == 8'h47) begin
              cfg_idx_q <= '0;
              st_q      <= S_CFG_REQ;
            end else begin
              err_q  <= 1'b1;
              done_q <= 1'b0;
              tmr_q  <= 32'(RETRY_CYC - 1);
              st_q   <= S_RETRY;
            end
          end
        end
        S_RETRY: begin
          if (tmr_q == 32'd0) st_q <= S_WHO_REQ;
          else tmr_q <= tmr_q - 32'd1;
        end
        S_CFG_REQ: begin
          if (eng_idle) begin
            start_q  <= 1'b1;
            nbytes_q <= 4'd2;
            case (cfg_idx_q)
              2'd0:    begin cmd_q <= 8'h11; wdat_q <= 8'h01; end
              2'd1:    begin cmd_q <= 8'h4E; wdat_q <= 8'h0F; end
              2'd2:    begin cmd_q <= 8'h4F; wdat_q <= 8'h06; end
              default: begin cmd_q <= 8'h50; wdat_q <= 8'h06; end
            endcase
            st_q <= S_CFG_WAIT;
          end
        end
        S_CFG_WAIT: begin
          if (xfer_end_q) begin
            cfg_idx_q <= cfg_idx_q + 2'd1;
            // soft reset and power-mode writes need 1 ms to settle
            if (cfg_idx_q < 2'd2) begin
              tmr_q <= 32'(MS_CYC - 1);
              st_q  <= S_CFG_DLY;
            end else if (cfg_idx_q == 2'd3) begin
              err_q  <= 1'b0;
              done_q <= 1'b1;
              st_q   <= S_RUN;
            end else begin
              st_q <= S_CFG_REQ;
            end
          end
        end
        S_CFG_DLY: begin
          if (tmr_q == 32'd0) st_q <= S_CFG_REQ;
          else tmr_q <= tmr_q - 32'd1;
        end
        S_RUN: begin
          if (tick_q) begin
            tick_q <= 1'b0;
`ifdef ICM42688_DRDY_POLL_EN
            st_q <= S_POLL_REQ;
`else
            st_q <= S_BURST_REQ;
`endif
          end
        end
        S_BURST_REQ: begin
          if (eng_idle) begin
            start_q  <= 1'b1;
            cmd_q    <= 8'h9D;
            wdat_q   <= 8'h00;
            nbytes_q <= 4'd15;
            st_q     <= S_BURST_WAIT;
          end
        end
        S_BURST_WAIT: begin
          if (xfer_end_q) begin
            tp_q <= {rx_buf_q[0],  rx_buf_q[1]};
            ax_q <= {rx_buf_q[2],  rx_buf_q[3]};
            ay_q <= {rx_buf_q[4],  rx_buf_q[5]};
            az_q <= {rx_buf_q[6],  rx_buf_q[7]};
            gx_q <= {rx_buf_q[8],  rx_buf_q[9]};
            gy_q <= {rx_buf_q[10], rx_buf_q[11]};
            gz_q <= {rx_buf_q[12], rx_buf_q[13]};
            dv_q <= 1'b1;
            st_q <= S_RUN;
          end
        end
        S_POLL_REQ: begin
          if (eng_idle) begin
            start_q  <= 1'b1;
            cmd_q    <= 8'hAD;
            wdat_q   <= 8'h00;
            nbytes_q <= 4'd2;
            st_q     <= S_POLL_WAIT;
          end
        end
        S_POLL_WAIT: begin
          if (xfer_end_q) begin
            if (rx_buf_q[0][3]) begin
              st_q <= S_BURST_REQ;
            end else begin
              tmr_q <= 32'(2 * CLK_DIV - 1);
              st_q  <= S_POLL_DLY;
            end
          end
        end
        default: begin
          if (tmr_q == 32'd0) st_q <= S_POLL_REQ;
          else tmr_q <= tmr_q - 32'd1;
        end
      endcase
    end
  end

  assign accel_x_o    = ax_q;
  assign accel_y_o    = ay_q;
  assign accel_z_o    = az_q;
  assign gyro_x_o     = gx_q;
  assign gyro_y_o     = gy_q;
  assign gyro_z_o     = gz_q;
  assign temp_o       = tp_q;
  assign data_valid_o = dv_q;
  assign init_done_o  = done_q;
  assign error_o      = err_q;
  assign spi_sck_o    = sck_q;
  assign spi_mosi_o   = mosi_q;
  assign spi_cs_n_o   = cs_n_q;

endmodule

// File: tb/tb_icm42688_ctrl.sv
// Directed bench for icm42688_ctrl with a behavioural mode-0 SPI slave holding a register map.
module tb_icm42688_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_miso = 1'b0;
  logic signed [15:0] ax, ay, az, gx, gy, gz, tp;
  logic dv, done, err, sck, mosi, cs_n;

  always #5 clk = ~clk;

  icm42688_ctrl #(.SYS_CLK_HZ(10_000), .SPI_CLK_HZ(1_000), .CLK_DIV(5), .SAMPLE_HZ(1000)) dut (
    .clk_i(clk), .rst_i(rst),
    .accel_x_o(ax), .accel_y_o(ay), .accel_z_o(az),
    .gyro_x_o(gx), .gyro_y_o(gy), .gyro_z_o(gz), .temp_o(tp),
    .data_valid_o(dv), .init_done_o(done), .error_o(err),
    .spi_sck_o(sck), .spi_mosi_o(mosi), .spi_miso_i(spi_miso), .spi_cs_n_o(cs_n)
  );

  // ---- SPI slave model ----
  logic [7:0] mem [128];
  logic [7:0] rsh, tsh;
  logic       rd;
  logic [6:0] addr;
  int         bcnt, wn;
  logic [6:0] wlog [8];
  logic [7:0] wdlog [8];

  always @(negedge cs_n) begin
    bcnt = 0;
    spi_miso = 1'b0;
  end

  always @(posedge sck) if (!cs_n) begin
    rsh = {rsh[6:0], mosi};
    bcnt++;
    if (bcnt % 8 == 0) begin
      if (bcnt == 8) begin
        rd = rsh[7];
        addr = rsh[6:0];
      end else if (!rd) begin
        mem[addr] = rsh;
        if (wn < 8) begin wlog[wn] = addr; wdlog[wn] = rsh; end
        wn++;
        addr++;
      end
      if (rd) begin tsh = mem[addr]; addr++; end
    end
  end

  always @(negedge sck) if (!cs_n) begin
    spi_miso = tsh[7];
    tsh = {tsh[6:0], 1'b0};
  end

  // ---- checking ----
  int n_tests = 0, n_fail = 0;
  logic init_phase = 1'b0, err_seen = 1'b0, both_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (init_phase && err) err_seen = 1'b1;
    if (done && err) both_seen = 1'b1;
  end

  logic [7:0] burst [14] = '{8'h00, 8'h64, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A,
                             8'hBC, 8'hDE, 8'hF0, 8'h11, 8'h22, 8'h33, 8'h44};

  task automatic check_sample(input string tag);
    chk({tag, "_temp"}, {tp}, 16'h0064);
    chk({tag, "_ax"},   {ax}, 16'h1234);
    chk({tag, "_ay"},   {ay}, 16'h5678);
    chk({tag, "_az"},   {az}, 16'h9ABC);
    chk({tag, "_gx"},   {gx}, 16'hDEF0);
    chk({tag, "_gy"},   {gy}, 16'h1122);
    chk({tag, "_gz"},   {gz}, 16'h3344);
  endtask

  initial begin
    int hw;
    logic prev;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h75] = 8'h47;
    for (int i = 0; i < 14; i++) mem[7'h1D + i] = burst[i];
    wn = 0; bcnt = 0; rd = 1'b0; addr = '0; rsh = '0; tsh = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_spi", {cs_n, sck, mosi}, 3'b100);
    chk("rst_flags", {dv, done, err}, 3'b000);
    chk("rst_data", {ax, ay, az, gx, gy, gz, tp}, 0);

    // bring-up
    init_phase = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 200000 && !done; i++) @(negedge clk);
    init_phase = 1'b0;
    chk("init_done", done, 1'b1);
    chk("init_no_err", err_seen, 1'b0);
    chk("cfg_wr_n", wn, 4);
    chk("cfg_wr0", {wlog[0], wdlog[0]}, {7'h11, 8'h01});
    chk("cfg_wr1", {wlog[1], wdlog[1]}, {7'h4E, 8'h0F});
    chk("cfg_wr2", {wlog[2], wdlog[2]}, {7'h4F, 8'h06});
    chk("cfg_wr3", {wlog[3], wdlog[3]}, {7'h50, 8'h06});

    // SCK high half-period
    prev = sck;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!prev && sck) break;
      prev = sck;
    end
    hw = 0;
    while (sck && hw < 100) begin @(negedge clk); hw++; end
    chk("sck_half", hw, 5);

    // first sample and pulse width
    for (int i = 0; i < 50000 && !dv; i++) @(negedge clk);
    chk("dv_first", dv, 1'b1);
    check_sample("s0");
    @(negedge clk);
    chk("dv_width", dv, 1'b0);
    chk("hold_ax", {ax}, 16'h1234);

    // three consecutive pulses
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 50000 && !dv; i++) @(negedge clk);
      chk($sformatf("dv_pulse%0d", k), dv, 1'b1);
      chk($sformatf("dv_gz%0d", k), {gz}, 16'h3344);
      @(negedge clk);
    end

    // bad WHO_AM_I
    mem[7'h75] = 8'hFF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 200000 && !err; i++) @(negedge clk);
    chk("who_err", err, 1'b1);
    chk("who_err_done", done, 1'b0);

    // recover without reset
    mem[7'h75] = 8'h47;
    for (int i = 0; i < 1000000 && !done; i++) @(negedge clk);
    chk("retry_done", done, 1'b1);
    chk("retry_err", err, 1'b0);

    // reset in the middle of a burst
    for (int i = 0; i < 50000 && !dv; i++) @(negedge clk);
    chk("pre_rst_dv", dv, 1'b1);
    for (int i = 0; i < 50000 && cs_n; i++) @(negedge clk);
    chk("pre_rst_cs", cs_n, 1'b0);
    repeat (23) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_spi", {cs_n, sck, mosi}, 3'b100);
    chk("mid_rst_flags", {dv, done, err}, 3'b000);
    chk("mid_rst_data", {ax, ay, az, gx, gy, gz, tp}, 0);
    chk("never_both", both_seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icm42688_ctrl.md
Name: icm42688_ctrl

Overview:
- Autonomous SPI master controller for the TDK ICM-42688-P 6-axis IMU.
- After reset: waits for power-up, checks WHO_AM_I, and configures the sensor.
- Then continuously burst-reads temperature, accel and gyro, presenting signed 16-bit samples with a one-cycle valid strobe.
- Sits between the IMU pins and the sensor-fusion/telemetry logic.

Parameters:
- SYS_CLK_HZ, 100_000_000, system clock frequency; all ms delays are derived from it.
- SPI_CLK_HZ, 1_000_000, nominal SCK frequency (documentation/derivation only).
- CLK_DIV, SYS_CLK_HZ/(2*SPI_CLK_HZ), clk_i cycles per SCK half-period (min 2).
- SAMPLE_HZ, 1000, burst-read rate; if one burst takes longer than the period, bursts run back-to-back.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- accel_x_o/accel_y_o/accel_z_o  out  16 signed  accelerometer X/Y/Z
- gyro_x_o/gyro_y_o/gyro_z_o  out  16 signed  gyroscope X/Y/Z
- temp_o  out  16 signed  raw temperature
- data_valid_o  out  1  one-cycle pulse when all seven outputs update together
- init_done_o  out  1  high while the device is configured and streaming
- error_o  out  1  high after a WHO_AM_I mismatch, until a retry succeeds
- spi_sck_o  out  1  SPI clock
- spi_mosi_o  out  1  SPI data out
- spi_miso_i  in  1  SPI data in
- spi_cs_n_o  out  1  chip select, active-low

Behaviour:
- Reset values (also on rst_i asserted mid-transfer):
  - all data outputs 0; data_valid_o, init_done_o, error_o at 0;
  - sck 0, mosi 0, cs_n 1;
  - the FSM restarts at PWR_WAIT, and the in-flight transaction is abandoned immediately.
- SPI mode 0:
  - MSB first; SCK idles low.
  - MOSI is valid when CS falls and changes on each SCK falling edge.
  - MISO is sampled on each SCK rising edge.
  - Each SCK half-period is CLK_DIV clk_i cycles.
  - CS stays high for at least 2*CLK_DIV cycles between transactions.
- Transaction format:
  - Command byte {rw, addr[6:0]}, rw=1 for read.
  - Write: command plus one data byte.
  - Read: command plus N bytes, with the address auto-incremented by the device.
- FSM states and transitions:
  - PWR_WAIT: wait 1 ms.
  - WHOAMI: read 0x75.
    - If 0x47: go to CFG.
    - Else: error_o=1, init_done_o=0, wait 10 ms (RETRY), then go back to WHOAMI.
  - CFG: write, in order:
    - 0x11 <= 0x01 (soft reset), then wait 1 ms;
    - 0x4E <= 0x0F (gyro+accel low-noise), then wait 1 ms;
    - 0x4F <= 0x06 (gyro 2000 dps, 1 kHz);
    - 0x50 <= 0x06 (accel 16 g, 1 kHz).
  - RUN: on entry, error_o=0 and init_done_o=1.
    - Each sample tick, burst-read 14 bytes starting at 0x1D.
- Byte mapping, big-endian (high byte at the lower address):
  - temp = 0x1D:0x1E
  - accel_x = 0x1F:0x20, accel_y = 0x21:0x22, accel_z = 0x23:0x24
  - gyro_x = 0x25:0x26, gyro_y = 0x27:0x28, gyro_z = 0x29:0x2A
- Output update:
  - Outputs update atomically in the cycle after CS deasserts.
  - data_valid_o pulses high in that same cycle.
  - Outputs hold their value between updates.
- Init failure does not halt the block; it retries forever.
- init_done_o and error_o are never both high.

Optional Feature:
- Macro ICM42688_DRDY_POLL_EN.
- When defined: in RUN, each sample tick first reads INT_STATUS 0x2D.
  - The burst read happens only if bit 3 (DATA_RDY) = 1.
  - Otherwise the block re-polls after 2*CLK_DIV cycles.
- When undefined: bursts are purely timer-driven (SAMPLE_HZ).

Test Plan (SYS_CLK_HZ=10_000, SPI_CLK_HZ=1_000, CLK_DIV=5, macro undefined; SPI slave model with 0x75=0x47 and 0x1D..0x2A = 00 64 12 34 56 78 9A BC DE F0 11 22 33 44):
- Release reset -> init_done_o=1 within 200000 cycles, with error_o=0 throughout; SCK half-period = 5 cycles; the four CFG writes land in the model with the listed values.
- After init -> data_valid_o pulses within 50000 cycles and is exactly 1 cycle wide.
- At a data_valid_o pulse:
  - accel_x=0x1234, accel_y=0x5678, accel_z=0x9ABC;
  - gyro_x=0xDEF0, gyro_y=0x1122, gyro_z=0x3344;
  - temp=0x0064.
- Three consecutive data_valid_o pulses are each seen within 50000 cycles.
- Reset with the model returning 0xFF for WHO_AM_I -> error_o=1 and init_done_o=0 within 200000 cycles.
- Fix WHO_AM_I without resetting -> init_done_o=1 and error_o=0 within 1000000 cycles.
- Assert rst_i mid-burst -> cs_n=1, sck=0 and all outputs at 0 immediately.
